// File: rtl/paper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : paper_pkg
// Purpose  : Shared opcode constants, FSM state encoding and a small opcode
//            helper for the instruction sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package paper_pkg;

   // Opcodes carried in prog_data[PC_W+1:PC_W]
   localparam logic [1:0] OP_INC = 2'b00;
   localparam logic [1:0] OP_DEC = 2'b01;
   localparam logic [1:0] OP_JNO = 2'b10;
   localparam logic [1:0] OP_STP = 2'b11;

   // Sequencer state encoding
   localparam int         STATE_W  = 3;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_ISSUE = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_HALT  = 3'd4;

   // INC and DEC are the only opcodes handed to an execution unit
   function automatic logic is_exec_op(input logic [1:0] op);
      return (op == OP_INC) || (op == OP_DEC);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_counter.sv
`default_nettype none
// ============================================================================
// Module   : pc_counter
// Purpose  : Program counter with synchronous reset, load, increment and
//            hold. Load has priority over increment; increment wraps
//            modulo 2^PC_W.
// Revision : 1.0 - initial release
// ============================================================================
module pc_counter #(
   parameter int PC_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            inc,
   input  logic [PC_W-1:0] load_val,
   output logic [PC_W-1:0] pc
);

   // PC register: reset, then load, then increment, otherwise hold
   always_ff @(posedge clk) begin
      if (rst)
         pc <= '0;
      else if (load)
         pc <= load_val;
      else if (inc)
         pc <= pc + PC_W'(1);
   end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Purpose  : Fetches 2-bit opcodes from a combinational ROM, issues INC/DEC
//            to an execution unit and waits for completion, evaluates JNO
//            against the captured status flag, and halts on STP.
// Options  : SEQ_TIMEOUT_EN - adds a WAIT watchdog; TIMEOUT consecutive WAIT
//            cycles without mn raise err and force HALT.
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer
   import paper_pkg::*;
#(
   parameter int PC_W    = 4,
   parameter int TIMEOUT = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [PC_W-1:0] prog_addr,
   input  logic [PC_W+1:0] prog_data,
   output logic [1:0]      instruct,
   output logic            pulser,
   input  logic            mn,
   input  logic            sta,
   output logic            busy,
   output logic            halted,
   output logic            err
);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_nxt;
   logic [1:0]         ir_op;
   logic [PC_W-1:0]    ir_tgt;
   logic               status_flag;
   logic               start_ok;
   logic               timeout_hit;
   logic               pc_load;
   logic               pc_inc;
   logic [PC_W-1:0]    pc_load_val;

   if (TIMEOUT < 1) begin : g_timeout_check
      $error("instr_sequencer: TIMEOUT must be at least 1");
   end

   // start is honoured only from the two resting states
   assign start_ok = start && ((state == ST_IDLE) || (state == ST_HALT));

`ifdef SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wait_cnt;

   // Count consecutive WAIT cycles without completion; cleared on leaving WAIT
   always_ff @(posedge clk) begin
      if (rst || (state != ST_WAIT) || mn)
         wait_cnt <= '0;
      else
         wait_cnt <= wait_cnt + CNT_W'(1);
   end

   // mn on the final allowed cycle wins over the watchdog
   assign timeout_hit = (state == ST_WAIT) && !mn && (wait_cnt == CNT_W'(TIMEOUT - 1));

   // Sticky watchdog error, cleared by reset or an accepted start
   always_ff @(posedge clk) begin
      if (rst)
         err <= 1'b0;
      else if (start_ok)
         err <= 1'b0;
      else if (timeout_hit)
         err <= 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_HALT: if (start) state_nxt = ST_FETCH;
         ST_FETCH:         state_nxt = ST_ISSUE;
         ST_ISSUE: begin
            if (is_exec_op(ir_op))
               state_nxt = ST_WAIT;
            else if (ir_op == OP_JNO)
               state_nxt = ST_FETCH;
            else
               state_nxt = ST_HALT;
         end
         ST_WAIT: begin
            if (mn)
               state_nxt = ST_FETCH;
            else if (timeout_hit)
               state_nxt = ST_HALT;
         end
         default:          state_nxt = ST_IDLE;
      endcase
   end

   // Output and PC-control decode
   always_comb begin
      busy        = (state == ST_FETCH) || (state == ST_ISSUE) || (state == ST_WAIT);
      halted      = (state == ST_HALT);
      instruct    = ((state == ST_ISSUE) || (state == ST_WAIT)) ? ir_op : OP_INC;
      pulser      = (state == ST_ISSUE) && is_exec_op(ir_op);
      pc_load     = 1'b0;
      pc_inc      = 1'b0;
      pc_load_val = '0;
      case (state)
         ST_IDLE, ST_HALT: pc_load = start;
         ST_ISSUE: begin
            if (ir_op == OP_JNO) begin
               pc_load     = !status_flag;
               pc_inc      = status_flag;
               pc_load_val = ir_tgt;
            end
         end
         ST_WAIT:          pc_inc = mn;
         default:          ;
      endcase
   end

   // Instruction register and status flag
   always_ff @(posedge clk) begin
      if (rst) begin
         ir_op       <= OP_INC;
         ir_tgt      <= '0;
         status_flag <= 1'b0;
      end else begin
         if (start_ok)
            status_flag <= 1'b0;
         else if ((state == ST_WAIT) && mn)
            status_flag <= sta;
         if (state == ST_FETCH)
            {ir_op, ir_tgt} <= prog_data;
      end
   end

   pc_counter #(
      .PC_W     (PC_W)
   ) u_pc (
      .clk      (clk),
      .rst      (rst),
      .load     (pc_load),
      .inc      (pc_inc),
      .load_val (pc_load_val),
      .pc       (prog_addr)
   );

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Purpose  : Self-checking bench for instr_sequencer using an
//            instruction-level reference model and reactive mn responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

   localparam int PC_W    = 4;
   localparam int TIMEOUT = 8;
   localparam int DEPTH   = 16;
   localparam int MAXI    = 20;
   localparam int NRESP   = 64;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic            mn = 1'b0;
   logic            sta = 1'b0;
   logic [PC_W-1:0] prog_addr;
   logic [PC_W+1:0] prog_data;
   logic [1:0]      instruct;
   logic            pulser;
   logic            busy;
   logic            halted;
   logic            err;

   logic [PC_W+1:0] rom [DEPTH];
   int              dly [NRESP];
   bit              stas [NRESP];
   int              noise_mode;

   int compared   = 0;
   int mismatched = 0;

   int exp_cyc[$], exp_op[$], exp_pc[$];
   int obs_cyc[$], obs_op[$], obs_pc[$];
   int exp_end, exp_pcf;
   bit exp_halt;

   always #5 clk = ~clk;

   assign prog_data = rom[prog_addr];

   instr_sequencer #(.PC_W(PC_W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .instruct  (instruct),
      .pulser    (pulser),
      .mn        (mn),
      .sta       (sta),
      .busy      (busy),
      .halted    (halted),
      .err       (err)
   );

   function automatic logic [5:0] ins(input logic [1:0] op, input int t);
      return {op, 4'(t)};
   endfunction

   task automatic fill_rom(input logic [5:0] v);
      for (int i = 0; i < DEPTH; i++) rom[i] = v;
   endtask

   task automatic set_resp(input int d, input bit s);
      for (int i = 0; i < NRESP; i++) begin dly[i] = d; stas[i] = s; end
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1; start = 1'b0; mn = 1'b0;
      @(negedge clk); rst = 1'b0;
   endtask

   // Instruction-level model: when each issue happens, and where the run ends
   task automatic model_run();
      int pc = 0, c = 0, k = 0;
      bit flag = 0;
      logic [1:0] op;
      int tg;
      exp_cyc.delete(); exp_op.delete(); exp_pc.delete();
      exp_halt = 0;
      for (int n = 0; n < MAXI; n++) begin
         op = rom[pc][5:4];
         tg = int'(rom[pc][3:0]);
         if (op == 2'b00 || op == 2'b01) begin
            exp_cyc.push_back(c + 1); exp_op.push_back(int'(op)); exp_pc.push_back(pc);
            flag = stas[k]; c = c + 2 + dly[k]; k++;
            pc = (pc + 1) % DEPTH;
         end else if (op == 2'b10) begin
            pc = flag ? (pc + 1) % DEPTH : tg;
            c = c + 2;
         end else begin
            exp_halt = 1; c = c + 2;
            break;
         end
      end
      exp_end = c;
      exp_pcf = pc;
   endtask

   task automatic run_program(input string name);
      int sched = -1, k = 0;
      bit sta_v = 0;
      int n;
      model_run();
      obs_cyc.delete(); obs_op.delete(); obs_pc.delete();
      @(negedge clk); start = 1'b1; mn = 1'b0;
      for (int cyc = 0; cyc <= exp_end; cyc++) begin
         @(negedge clk); start = 1'b0;
         if (pulser) begin
            obs_cyc.push_back(cyc); obs_op.push_back(int'(instruct)); obs_pc.push_back(int'(prog_addr));
            if (k < NRESP) begin sched = cyc + dly[k]; sta_v = stas[k]; end
            k++;
         end
         if (cyc == sched) begin
            mn = 1'b1; sta = sta_v;
         end else if (sched > cyc) begin
            mn = 1'b0; sta = 1'($urandom);
         end else if (noise_mode == 1) begin
            mn = 1'($urandom); sta = 1'($urandom);
         end else if (noise_mode == 2) begin
            mn = 1'b1; sta = 1'b1;
         end else begin
            mn = 1'b0;
         end
      end
      mn = 1'b0;
      compared++;
      if (obs_cyc.size() !== exp_cyc.size()) begin
         mismatched++;
         $display("FAIL %s issue_count: got %0d expected %0d", name, obs_cyc.size(), exp_cyc.size());
      end
      n = (obs_cyc.size() < exp_cyc.size()) ? obs_cyc.size() : exp_cyc.size();
      for (int i = 0; i < n; i++) begin
         compared++;
         if (obs_cyc[i] !== exp_cyc[i] || obs_op[i] !== exp_op[i] || obs_pc[i] !== exp_pc[i]) begin
            mismatched++;
            $display("FAIL %s issue[%0d]: got cyc=%0d op=%0d pc=%0d expected cyc=%0d op=%0d pc=%0d",
                     name, i, obs_cyc[i], obs_op[i], obs_pc[i], exp_cyc[i], exp_op[i], exp_pc[i]);
         end
      end
      compared++;
      if (halted !== exp_halt || busy !== !exp_halt || int'(prog_addr) !== exp_pcf || err !== 1'b0) begin
         mismatched++;
         $display("FAIL %s end_state: got halted=%b busy=%b pc=%0d err=%b expected halted=%b busy=%b pc=%0d err=0",
                  name, halted, busy, prog_addr, err, exp_halt, !exp_halt, exp_pcf);
      end
      do_reset();
   endtask

   // Starts the loaded program and returns once the first issue strobe is seen
   task automatic start_until_pulse(input string name, output bit ok);
      ok = 0;
      @(negedge clk); start = 1'b1; mn = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk); start = 1'b0;
         if (pulser) ok = 1;
      end
      if (!ok) begin
         compared++; mismatched++;
         $display("FAIL %s pulse_wait: got no pulser expected pulser within 20 cycles", name);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      compared++;
      if (prog_addr !== '0 || instruct !== 2'b00 || pulser !== 1'b0 ||
          busy !== 1'b0 || halted !== 1'b0 || err !== 1'b0) begin
         mismatched++;
         $display("FAIL %s: got pc=%0d instr=%0d pulser=%b busy=%b halted=%b err=%b expected all zero",
                  name, prog_addr, instruct, pulser, busy, halted, err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_state");
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("idle_after_reset");
   endtask

   task automatic test_inc_program();
      fill_rom(ins(2'b11, 0));
      rom[0] = ins(2'b00, 0); rom[1] = ins(2'b00, 0); rom[2] = ins(2'b11, 0);
      set_resp(2, 0); noise_mode = 0;
      run_program("inc_inc_stp");
   endtask

   task automatic test_jno();
      fill_rom(ins(2'b11, 0));
      rom[0] = ins(2'b01, 0); rom[1] = ins(2'b10, 0); rom[2] = ins(2'b11, 0);
      set_resp(1, 0); noise_mode = 0;
      run_program("jno_taken_loop");
      set_resp(3, 1);
      run_program("jno_not_taken");
   endtask

   task automatic test_mn_ignored();
      mn = 1'b1; sta = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         compared++;
         if (prog_addr !== '0 || busy !== 1'b0 || halted !== 1'b0) begin
            mismatched++;
            $display("FAIL mn_in_idle: got pc=%0d busy=%b halted=%b expected 0 0 0", prog_addr, busy, halted);
         end
      end
      mn = 1'b0;
      fill_rom(ins(2'b11, 0));
      rom[0] = ins(2'b10, 5);
      set_resp(1, 0); noise_mode = 2;
      run_program("mn_in_fetch_issue");
   endtask

   task automatic test_reset_mid_wait();
      bit ok;
      fill_rom(ins(2'b11, 0));
      rom[0] = ins(2'b00, 0);
      start_until_pulse("rst_mid_wait", ok);
      @(negedge clk);
      rst = 1'b1; start = 1'b1; mn = 1'b1; sta = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0; mn = 1'b0;
      check_reset_outputs("rst_mid_wait");
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      compared++;
      if (prog_addr !== '0 || busy !== 1'b1 || halted !== 1'b0) begin
         mismatched++;
         $display("FAIL restart_after_rst: got pc=%0d busy=%b halted=%b expected 0 1 0", prog_addr, busy, halted);
      end
      do_reset();
   endtask

   task automatic test_wrap();
      fill_rom(ins(2'b11, 0));
      rom[0]  = ins(2'b10, 14);
      rom[14] = ins(2'b00, 0);
      rom[15] = ins(2'b10, 7);
      set_resp(2, 1); noise_mode = 0;
      run_program("pc_wrap");
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < DEPTH; i++) rom[i] = 6'($urandom);
         for (int i = 0; i < NRESP; i++) begin
            dly[i] = int'($urandom_range(1, 3)); stas[i] = 1'($urandom);
         end
         noise_mode = 1;
         run_program($sformatf("random_%0d", r));
      end
   endtask

   task automatic test_timeout();
      bit ok;
      fill_rom(ins(2'b11, 0));
      rom[0] = ins(2'b00, 0);
`ifdef SEQ_TIMEOUT_EN
      start_until_pulse("timeout", ok);
      for (int i = 1; i <= TIMEOUT; i++) begin
         @(negedge clk); mn = 1'b0;
      end
      compared++;
      if (halted !== 1'b0 || busy !== 1'b1) begin
         mismatched++;
         $display("FAIL timeout_early: got halted=%b busy=%b expected 0 1", halted, busy);
      end
      @(negedge clk);
      compared++;
      if (halted !== 1'b1 || err !== 1'b1 || prog_addr !== '0) begin
         mismatched++;
         $display("FAIL timeout_hit: got halted=%b err=%b pc=%0d expected 1 1 0", halted, err, prog_addr);
      end
      start = 1'b1; @(negedge clk); start = 1'b0;
      compared++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         mismatched++;
         $display("FAIL err_clear_on_start: got err=%b busy=%b expected 0 1", err, busy);
      end
      do_reset();
      start_until_pulse("timeout_mn_last", ok);
      for (int i = 1; i <= TIMEOUT; i++) begin
         @(negedge clk); mn = (i == TIMEOUT); sta = 1'b0;
      end
      @(negedge clk); mn = 1'b0;
      compared++;
      if (err !== 1'b0 || halted !== 1'b0 || busy !== 1'b1 || prog_addr !== 4'd1) begin
         mismatched++;
         $display("FAIL timeout_mn_wins: got err=%b halted=%b busy=%b pc=%0d expected 0 0 1 1",
                  err, halted, busy, prog_addr);
      end
`else
      start_until_pulse("no_timeout", ok);
      repeat (3 * TIMEOUT) @(negedge clk);
      compared++;
      if (err !== 1'b0 || halted !== 1'b0 || busy !== 1'b1 || prog_addr !== '0) begin
         mismatched++;
         $display("FAIL wait_forever: got err=%b halted=%b busy=%b pc=%0d expected 0 0 1 0",
                  err, halted, busy, prog_addr);
      end
`endif
      do_reset();
   endtask

   initial begin
      noise_mode = 0;
      fill_rom(ins(2'b11, 0));
      set_resp(1, 0);
      test_reset();
      test_inc_program();
      test_jno();
      test_mn_ignored();
      test_reset_mid_wait();
      test_wrap();
      test_timeout();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no completion expected finish before 500us");
      $fatal(1, "simulation time limit reached");
   end

endmodule
`default_nettype wire
